majority3_bist: RTL and testbench

MAJORITY3_BIST -- requirements
Module: majority3_bist

---
 rtl/majority3_bist_pkg.sv | 12 +
 rtl/majority3.sv | 11 +
 rtl/majority3_bist.sv | 102 ++++++++++
 tb/tb_majority3_bist.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/majority3_bist_pkg.sv
// majority3_bist_pkg: shared state encoding, vector count and golden majority reference.
package majority3_bist_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} state_t;

    localparam int NUM_VECTORS = 8;

    function automatic logic golden_maj(input logic [2:0] v);
        return (v[2] & v[1]) | (v[1] & v[0]) | (v[2] & v[0]);
    endfunction

endpackage

// File: rtl/majority3.sv
// majority3: combinational 3-input majority gate under test.
module majority3 (
    input  logic A,
    input  logic B,
    input  logic C,
    output logic Y
);

    assign Y = (A & B) | (B & C) | (A & C);

endmodule

// File: rtl/majority3_bist.sv
// majority3_bist: built-in self-test that sweeps all eight input vectors through majority3
// and records per-vector failures, a saturating failure count and a pass flag.
module majority3_bist #(
    parameter int SETTLE_CYCLES = 2,
    parameter int LOOPS         = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       fault_inject,
    output logic       vec_A,
    output logic       vec_B,
    output logic       vec_C,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] fail_vec,
    output logic [3:0] fail_count
);

    import majority3_bist_pkg::*;

    localparam logic [3:0] LAST_SETTLE = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0] LAST_LOOP   = 4'(LOOPS - 1);
    localparam logic [2:0] LAST_VEC    = 3'(NUM_VECTORS - 1);

    state_t     state;
    logic [2:0] vector;
    logic [3:0] loop;
    logic [3:0] settle;
    logic       y;
    logic       mismatch;

    // The vector is only presented while a run is active; busy gates it to zero otherwise.
    assign vec_A = busy & vector[2];
    assign vec_B = busy & vector[1];
    assign vec_C = busy & vector[0];

    majority3 u_maj (
        .A(vec_A),
        .B(vec_B),
        .C(vec_C),
        .Y(y)
    );

    assign mismatch = (y ^ fault_inject) != golden_maj(vector);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            vector     <= '0;
            loop       <= '0;
            settle     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            fail_vec   <= '0;
            fail_count <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state      <= APPLY;
                    vector     <= '0;
                    loop       <= '0;
                    settle     <= '0;
                    busy       <= 1'b1;
                    pass       <= 1'b0;
                    fail_vec   <= '0;
                    fail_count <= '0;
                end
                APPLY: begin
                    settle <= settle == LAST_SETTLE ? 4'd0 : settle + 4'd1;
                    if (settle == LAST_SETTLE) state <= CHECK;
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_vec[vector] <= 1'b1;
                        fail_count       <= fail_count + 4'(fail_count != 4'd15);
                    end
                    if (vector != LAST_VEC) begin
                        vector <= vector + 3'd1;
                        state  <= APPLY;
                    end else if (loop != LAST_LOOP) begin
                        vector <= '0;
                        loop   <= loop + 4'd1;
                        state  <= APPLY;
                    end else begin
                        // Final check's mismatch is not yet in fail_count, so fold it in here.
                        pass  <= (fail_count == 4'd0) && !mismatch;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_majority3_bist.sv
// tb_majority3_bist: directed runs checked every cycle against a run-offset model,
// plus literal result checks and a LOOPS=2 instance for saturation and latency.
module tb_majority3_bist;

    localparam int S = 2;
    localparam int N = 8 * (S + 1);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, fault_inject = 1'b0;
    logic       vec_A, vec_B, vec_C, busy, done, pass;
    logic [7:0] fail_vec;
    logic [3:0] fail_count;
    logic       start2 = 1'b0, fault2 = 1'b0;
    logic       vA2, vB2, vC2, busy2, done2, pass2;
    logic [7:0] fail_vec2;
    logic [3:0] fail_count2;

    int tests = 0, fails = 0, done_cnt = 0;
    int n = 0, m_fc = 0;
    logic       m_done = 1'b0, m_pass = 1'b0;
    logic [7:0] m_fv = '0;

    majority3_bist #(.SETTLE_CYCLES(S), .LOOPS(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fault_inject(fault_inject),
        .vec_A(vec_A), .vec_B(vec_B), .vec_C(vec_C), .busy(busy), .done(done),
        .pass(pass), .fail_vec(fail_vec), .fail_count(fail_count)
    );

    majority3_bist #(.SETTLE_CYCLES(S), .LOOPS(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .fault_inject(fault2),
        .vec_A(vA2), .vec_B(vB2), .vec_C(vC2), .busy(busy2), .done(done2),
        .pass(pass2), .fail_vec(fail_vec2), .fail_count(fail_count2)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Model: n is the cycle offset within a run (1..N); vector and check slots follow arithmetically.
    always @(negedge clk) begin
        if (!rst_n) begin
            n = 0; m_done = 1'b0; m_pass = 1'b0; m_fv = '0; m_fc = 0;
        end
        chk("busy", 8'(busy), 8'(n != 0));
        chk("done", 8'(done), 8'(m_done));
        chk("vec", 8'({vec_A, vec_B, vec_C}), n != 0 ? 8'(((n - 1) / (S + 1)) % 8) : 8'd0);
        chk("pass", 8'(pass), 8'(m_pass));
        chk("fail_vec", fail_vec, m_fv);
        chk("fail_count", 8'(fail_count), 8'(m_fc));
        if (done) done_cnt++;
        if (rst_n) begin
            if (n != 0) begin
                if ((n - 1) % (S + 1) == S && fault_inject) begin
                    m_fv[((n - 1) / (S + 1)) % 8] = 1'b1;
                    m_fc = m_fc < 15 ? m_fc + 1 : 15;
                end
                if (n == N) begin
                    n = 0; m_done = 1'b1; m_pass = (m_fc == 0);
                end else n++;
            end else if (m_done) m_done = 1'b0;
            else if (start) begin
                n = 1; m_fv = '0; m_fc = 0; m_pass = 1'b0;
            end
        end
    end

    initial begin
        int d0, cnt, bcnt;
        tick(3);
        chk("rst_busy", 8'(busy), 8'd0);
        chk("rst_pass", 8'(pass), 8'd0);
        chk("rst_fc", 8'(fail_count), 8'd0);
        chk("rst_vec", 8'({vec_A, vec_B, vec_C}), 8'd0);
        rst_n = 1'b1;
        tick(2);

        // LOOPS=2 with fault: 16 mismatches saturate at 15, done 49 cycles after start edge.
        fault2 = 1'b1; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cnt = 1; bcnt = 0;
        while (!done2 && cnt < 60) begin
            if (busy2) bcnt++;
            tick();
            cnt++;
        end
        chk("l2_done_cycle", 8'(cnt), 8'd49);
        chk("l2_busy_cycles", 8'(bcnt), 8'd48);
        chk("l2_fc", 8'(fail_count2), 8'd15);
        chk("l2_fv", fail_vec2, 8'hFF);
        chk("l2_pass", 8'(pass2), 8'd0);
        fault2 = 1'b0;
        tick(2);

        // Clean run with start re-pulsed during busy and during DONE.
        d0 = done_cnt;
        start = 1'b1; tick(); start = 1'b0;
        tick(4); start = 1'b1; tick(); start = 1'b0;
        tick(19);
        chk("a_done", 8'(done), 8'd1);
        chk("a_pass", 8'(pass), 8'd1);
        chk("a_fv", fail_vec, 8'h00);
        chk("a_fc", 8'(fail_count), 8'd0);
        start = 1'b1; tick(); start = 1'b0;
        tick(3);
        chk("a_one_done", 8'(done_cnt - d0), 8'd1);
        chk("a_idle_busy", 8'(busy), 8'd0);

        // Fault for the whole run, start held so a second clean run follows immediately.
        fault_inject = 1'b1; start = 1'b1;
        tick(25);
        chk("b_done", 8'(done), 8'd1);
        chk("b_fv", fail_vec, 8'hFF);
        chk("b_fc", 8'(fail_count), 8'd8);
        chk("b_pass", 8'(pass), 8'd0);
        fault_inject = 1'b0;
        tick(2);
        chk("c_busy", 8'(busy), 8'd1);
        chk("c_cleared_fc", 8'(fail_count), 8'd0);
        chk("c_cleared_fv", fail_vec, 8'h00);
        start = 1'b0;
        tick(24);
        chk("c_pass", 8'(pass), 8'd1);
        tick(2);

        // Fault only during the check of vector 5.
        start = 1'b1; tick(); start = 1'b0;
        tick(17); fault_inject = 1'b1; tick(); fault_inject = 1'b0;
        tick(6);
        chk("d_done", 8'(done), 8'd1);
        chk("d_fv", fail_vec, 8'h20);
        chk("d_fc", 8'(fail_count), 8'd1);
        chk("d_pass", 8'(pass), 8'd0);
        tick(2);

        // Reset during APPLY of vector 3, then a clean run.
        start = 1'b1; tick(); start = 1'b0;
        tick(9);
        chk("e_vec3", 8'({vec_A, vec_B, vec_C}), 8'd3);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("e_rst_busy", 8'(busy), 8'd0);
        chk("e_rst_vec", 8'({vec_A, vec_B, vec_C}), 8'd0);
        chk("e_rst_fv", fail_vec, 8'h00);
        tick(2);
        rst_n = 1'b1; start = 1'b1; tick(); start = 1'b0;
        chk("e_restart_busy", 8'(busy), 8'd1);
        tick(24);
        chk("e_no_abort_done", 8'(done_cnt - d0), 8'd0);
        chk("e_done", 8'(done), 8'd1);
        chk("e_pass", 8'(pass), 8'd1);
        tick(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
